hc595_scan_driver: RTL and testbench

Scan controller for the 6-digit display chain built from two cascaded SN74HC595N shift registers. The first device drives the segment lines and the second drives the digit selects. Each digit-dwell period, the block serializes one 16-bit frame onto SER/SRCLK and latches it with RCLK, cycling through all digits continuously. It sits between the timer/stopwatch core, which supplies per-digit segment patterns, and the board pins of the shift-register chain. It owns all 595 control lines: SER, SRCLK, RCLK, nSRCLR and nOE.

---
 rtl/hc595_scan_driver.sv | 216 +++++++++++++++++++++
 tb/tb_hc595_scan_driver.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hc595_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : hc595_scan_driver
// Purpose  : Multiplexed scan controller for a 6-digit display built from two
//            cascaded SN74HC595 shift registers (segments in the first device,
//            one-hot digit selects in the second). Each digit slot serializes
//            a 16-bit frame MSB first on SER/SRCLK, latches it with RCLK, then
//            dwells until the slot period expires.
// Revision : 1.0 - initial release
// ============================================================================
module hc595_scan_driver #(
  parameter int CLK_DIV       = 4,
  parameter int DIGITS        = 6,
  parameter int REFRESH_TICKS = 50000
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic [8*DIGITS-1:0]   seg_data,
  input  logic                  blank,
  output logic                  SER,
  output logic                  SRCLK,
  output logic                  RCLK,
  output logic                  nSRCLR,
  output logic                  nOE,
  output logic [2:0]            digit_idx,
  output logic                  frame_done
);

  // --------------------------------------------------------------------------
  // Parameter sanity (elaboration-time)
  // --------------------------------------------------------------------------
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("hc595_scan_driver: CLK_DIV must be >= 1");
  end
  if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
    $error("hc595_scan_driver: DIGITS must be in 1..8");
  end
  if (REFRESH_TICKS < (33 * CLK_DIV + 2)) begin : g_bad_refresh
    $error("hc595_scan_driver: REFRESH_TICKS too small for one frame");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = $clog2(REFRESH_TICKS);

  localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(REFRESH_TICKS - 1);
  localparam logic [2:0]        C_PTR_LAST  = 3'(DIGITS - 1);
  localparam logic [3:0]        C_BIT_LAST  = 4'd15;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_DWELL = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [DIV_W-1:0]    r_div;       // phase-length counter (CLEAR/SHIFT/LATCH)
  logic [SLOT_W-1:0]   r_slot;      // cycle offset within the digit slot
  logic [3:0]          r_bit;       // bit being presented on SER
  logic [15:0]         r_shreg;     // frame bits still to be sent, MSB next
  logic [2:0]          r_ptr;       // digit being loaded / shifted
  logic                r_latched;   // at least one frame latched since reset

  logic                r_ser;
  logic                r_srclk;
  logic                r_rclk;
  logic                r_nsrclr;
  logic                r_noe;
  logic [2:0]          r_digit_idx;
  logic                r_frame_done;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [7:0] w_seg_byte;
  logic [7:0] w_sel;
  logic [2:0] w_ptr_next;

  // Pick the segment byte of the current digit out of the flat input bus
  always_comb begin
    w_seg_byte = 8'h00;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_ptr == 3'(i)) begin
        w_seg_byte = seg_data[8*i +: 8];
      end
    end
  end

  assign w_sel      = 8'(8'h01 << r_ptr);
  assign w_ptr_next = (r_ptr == C_PTR_LAST) ? 3'd0 : r_ptr + 3'd1;

  // --------------------------------------------------------------------------
  // Scan sequencer: CLEAR -> (LOAD -> SHIFT -> LATCH -> DWELL)*
  // --------------------------------------------------------------------------
  // Single registered FSM owning every 595 control line
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state      <= ST_CLEAR;
      r_div        <= '0;
      r_slot       <= '0;
      r_bit        <= 4'd0;
      r_shreg      <= 16'h0000;
      r_ptr        <= 3'd0;
      r_latched    <= 1'b0;
      r_ser        <= 1'b0;
      r_srclk      <= 1'b0;
      r_rclk       <= 1'b0;
      r_nsrclr     <= 1'b0;
      r_noe        <= 1'b1;
      r_digit_idx  <= 3'd0;
      r_frame_done <= 1'b0;
    end else begin
      // Defaults: pulse outputs drop, slot offset keeps counting
      r_frame_done <= 1'b0;
      r_slot       <= r_slot + SLOT_W'(1);

      // Display stays dark until a valid frame has been latched once
      if (r_latched) begin
        r_noe <= blank;
      end

      case (r_state)
        ST_CLEAR: begin
          if (r_div == C_DIV_LAST) begin
            r_div    <= '0;
            r_nsrclr <= 1'b1;
            r_ptr    <= 3'd0;
            r_slot   <= '0;
            r_state  <= ST_LOAD;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        ST_LOAD: begin
          // Snapshot the frame; first bit goes straight onto SER
          r_shreg <= {w_sel, w_seg_byte};
          r_ser   <= w_sel[7];
          r_srclk <= 1'b0;
          r_bit   <= 4'd0;
          r_div   <= '0;
          r_state <= ST_SHIFT;
        end

        ST_SHIFT: begin
          if (r_div == C_DIV_LAST) begin
            r_div <= '0;
            if (!r_srclk) begin
              r_srclk <= 1'b1;
            end else begin
              // SRCLK falls: either advance SER or finish the frame
              r_srclk <= 1'b0;
              if (r_bit == C_BIT_LAST) begin
                r_ser        <= 1'b0;
                r_rclk       <= 1'b1;
                r_frame_done <= 1'b1;
                r_digit_idx  <= r_ptr;
                r_latched    <= 1'b1;
                r_state      <= ST_LATCH;
              end else begin
                r_bit   <= r_bit + 4'd1;
                r_ser   <= r_shreg[14];
                r_shreg <= {r_shreg[14:0], 1'b0};
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        ST_LATCH: begin
          if (r_div == C_DIV_LAST) begin
            r_div   <= '0;
            r_rclk  <= 1'b0;
            r_state <= ST_DWELL;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        ST_DWELL: begin
          if (r_slot == C_SLOT_LAST) begin
            r_ptr   <= w_ptr_next;
            r_slot  <= '0;
            r_state <= ST_LOAD;
          end
        end

        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign SER        = r_ser;
  assign SRCLK      = r_srclk;
  assign RCLK       = r_rclk;
  assign nSRCLR     = r_nsrclr;
  assign nOE        = r_noe;
  assign digit_idx  = r_digit_idx;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_hc595_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc595_scan_driver
// Purpose  : Scoreboard bench for hc595_scan_driver with a behavioural model
//            of the two cascaded 595 devices on the outputs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hc595_scan_driver;

  localparam int CLK_DIV       = 2;
  localparam int DIGITS        = 6;
  localparam int REFRESH_TICKS = 100;
  localparam int FIRST_LATCH   = 67;   // period index of first RCLK high after release

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        blank = 1'b0;
  logic [47:0] seg_data = 48'h0;
  logic        SER, SRCLK, RCLK, nSRCLR, nOE, frame_done;
  logic [2:0]  digit_idx;

  hc595_scan_driver #(
    .CLK_DIV       (CLK_DIV),
    .DIGITS        (DIGITS),
    .REFRESH_TICKS (REFRESH_TICKS)
  ) u_dut (
    .clk        (clk),
    .nRST       (nRST),
    .seg_data   (seg_data),
    .blank      (blank),
    .SER        (SER),
    .SRCLK      (SRCLK),
    .RCLK       (RCLK),
    .nSRCLR     (nSRCLR),
    .nOE        (nOE),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural 595 pair: q[15:8] = digit-select device, q[7:0] = segment device
  logic [15:0] m_sr = 16'h0;
  logic [15:0] m_q  = 16'h0;
  always @(posedge SRCLK or negedge nSRCLR) begin
    if (!nSRCLR) m_sr <= 16'h0;
    else         m_sr <= {m_sr[14:0], SER};
  end
  always @(posedge RCLK) m_q <= m_sr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int s_idx = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  idx;
    logic [15:0] q;
  } exp_t;
  exp_t sb[$];

  // Hand-computed frames: {one-hot select, segment byte}
  logic [2:0]  tab_idx [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [15:0] tab_q   [10] = '{16'h0100, 16'h0200, 16'h0400, 16'h08A5, 16'h1000,
                                16'h2000, 16'h0100, 16'h023C, 16'h0400, 16'h08A5};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic goto_idx(input int k);
    while (s_idx < k) begin
      @(negedge clk);
      s_idx++;
    end
  endtask

  task automatic push_exp(input int c, input logic [2:0] i, input logic [15:0] q);
    exp_t e;
    e.cyc = c;
    e.idx = i;
    e.q   = q;
    sb.push_back(e);
  endtask

  // Monitor: counts SRCLK rises, watches overlap, scores every latched frame
  int   rises = 0;
  logic ovl = 1'b0;
  logic prev_srclk = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nRST) begin
        rises      = 0;
        ovl        = 1'b0;
        prev_srclk = 1'b0;
      end else begin
        if (SRCLK && !prev_srclk) rises++;
        prev_srclk = SRCLK;
        if (SRCLK && RCLK) ovl = 1'b1;
        if (frame_done) begin
          check("frame_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("frame_cycle", cyc, e.cyc);
            check("digit_idx", 32'(digit_idx), 32'(e.idx));
            check("latched_q", 32'(m_q), 32'(e.q));
            check("srclk_rises", rises, 16);
            check("srclk_rclk_overlap", 32'(ovl), 32'd0);
            check("rclk_high", 32'(RCLK), 32'd1);
          end
          rises = 0;
          ovl   = 1'b0;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int base;
    repeat (2) @(negedge clk);
    check("reset_outputs", 32'({SER, SRCLK, RCLK, nSRCLR, nOE, digit_idx, frame_done}), 32'h010);

    // ---- first release --------------------------------------------------
    @(posedge clk);
    #1 nRST = 1'b1;
    base  = cyc + 1;
    s_idx = -1;
    for (int k = 0; k < 10; k++) push_exp(base + FIRST_LATCH + 100*k, tab_idx[k], tab_q[k]);

    goto_idx(0);  check("clear_nsrclr_0", 32'(nSRCLR), 32'd0);
    goto_idx(1);  check("clear_nsrclr_1", 32'(nSRCLR), 32'd0);
    goto_idx(2);  check("load_nsrclr",    32'(nSRCLR), 32'd1);
    goto_idx(66); check("noe_before_latch", 32'(nOE), 32'd1);
    goto_idx(67); check("noe_at_latch",     32'(nOE), 32'd1);
    goto_idx(68); check("noe_after_latch",  32'(nOE), 32'd0);

    // Mid-SHIFT of slot 1: slot 1 keeps the old byte
    goto_idx(130);
    seg_data[15:8]  = 8'h3C;
    seg_data[31:24] = 8'hA5;

    // Blank window covering several latches
    goto_idx(650); check("noe_pre_blank", 32'(nOE), 32'd0);
    blank = 1'b1;
    goto_idx(651); check("noe_blank_on", 32'(nOE), 32'd1);
    goto_idx(800); check("noe_blank_hold", 32'(nOE), 32'd1);
    goto_idx(950); blank = 1'b0;
    goto_idx(951); check("noe_blank_off", 32'(nOE), 32'd0);

    // Reset in the middle of SHIFT of slot 10 (digit 4)
    goto_idx(1020);
    check("pre_reset_idx", 32'(digit_idx), 32'd3);
    check("pre_reset_nsrclr", 32'(nSRCLR), 32'd1);
    #1 nRST = 1'b0;
    #1 check("async_reset_outputs", 32'({SER, SRCLK, RCLK, nSRCLR, nOE, digit_idx, frame_done}), 32'h010);
    repeat (3) @(negedge clk);

    // ---- second release -------------------------------------------------
    @(posedge clk);
    #1 nRST = 1'b1;
    base  = cyc + 1;
    s_idx = -1;
    push_exp(base + FIRST_LATCH,       3'd0, 16'h0100);
    push_exp(base + FIRST_LATCH + 100, 3'd1, 16'h023C);

    goto_idx(0);  check("re_clear_nsrclr_0", 32'(nSRCLR), 32'd0);
    goto_idx(1);  check("re_clear_nsrclr_1", 32'(nSRCLR), 32'd0);
    goto_idx(2);  check("re_load_nsrclr",    32'(nSRCLR), 32'd1);
    goto_idx(67); check("re_noe_at_latch",   32'(nOE), 32'd1);
    goto_idx(68); check("re_noe_after_latch", 32'(nOE), 32'd0);
    goto_idx(200);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
